// File: rtl/load_store_unit.sv
// Data-side load/store initiator for the unified RAM: one outstanding RV32I load/store.
// Optional LSU_BOUNDS_CHECK_EN: addresses at or above DEPTH*4 return an error without a memory access.
module load_store_unit #(
  parameter int unsigned DEPTH       = 4096,
  parameter int unsigned ADDRW       = 32,
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [2:0]       req_funct3,
  input  logic [ADDRW-1:0] req_addr,
  input  logic [ADDRW-1:0] req_wdata,
  output logic             resp_valid,
  output logic [ADDRW-1:0] resp_rdata,
  output logic             resp_err,
  output logic [13:0]      mem_addr,
  output logic             mem_re,
  output logic             mem_we,
  output logic [3:0]       mem_wstrb,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  localparam logic [ADDRW:0] AddrLimit = (ADDRW + 1)'(DEPTH) << 2;

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  lane_q, lane_d;
  logic        err_q, err_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic [13:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;

  logic        misalign, illegal, oob, dec_err;
  logic [31:0] store_data;
  logic [3:0]  strb;
  logic [31:0] shifted, load_ext;

  // Alignment is judged by access size; stores only exist for B/H/W.
  assign misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                    ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
  assign illegal  = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) ||
                    (req_we && req_funct3[2]);
  assign oob      = ({1'b0, req_addr} >= AddrLimit);

`ifdef LSU_BOUNDS_CHECK_EN
  assign dec_err = misalign | illegal | oob;
`else
  assign dec_err = misalign | illegal;
  logic unused_oob;
  assign unused_oob = oob;
`endif

  always_comb begin
    store_data = req_wdata[31:0];
    unique case (req_funct3[1:0])
      2'b00:   store_data = {4{req_wdata[7:0]}};
      2'b01:   store_data = {2{req_wdata[15:0]}};
      default: store_data = req_wdata[31:0];
    endcase
  end

  always_comb begin
    strb = 4'b1111;
    unique case (funct3_q[1:0])
      2'b00:   strb = 4'b0001 << lane_q;
      2'b01:   strb = 4'b0011 << lane_q;
      default: strb = 4'b1111;
    endcase
  end

  // funct3[2] selects zero-extension for the sub-word loads.
  assign shifted = rdata_q >> {lane_q, 3'b000};
  always_comb begin
    load_ext = shifted;
    unique case (funct3_q[1:0])
      2'b00:   load_ext = {{24{~funct3_q[2] & shifted[7]}}, shifted[7:0]};
      2'b01:   load_ext = {{16{~funct3_q[2] & shifted[15]}}, shifted[15:0]};
      default: load_ext = shifted;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    funct3_d    = funct3_q;
    lane_d      = lane_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    rdata_d     = rdata_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    mem_re      = 1'b0;
    mem_we      = 1'b0;
    mem_wstrb   = 4'b0000;

    unique case (state_q)
      StIdle: begin
        req_ready = 1'b1;
        if (req_valid) begin
          we_d     = req_we;
          funct3_d = req_funct3;
          lane_d   = req_addr[1:0];
          err_d    = dec_err;
          if (dec_err) begin
            state_d = StResp;
          end else begin
            state_d    = StIssue;
            mem_addr_d = {req_addr[13:2], 2'b00};
            if (req_we) begin
              mem_wdata_d = store_data;
            end
          end
        end
      end
      StIssue: begin
        if (we_q) begin
          mem_we    = 1'b1;
          mem_wstrb = strb;
          state_d   = StResp;
        end else begin
          mem_re  = 1'b1;
          cnt_d   = 3'(MEM_LATENCY - 1);
          state_d = StWait;
        end
      end
      StWait: begin
        if (cnt_q == 3'd0) begin
          rdata_d = mem_rdata;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      StResp: begin
        resp_valid = 1'b1;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign resp_err   = (state_q == StResp) && err_q;
  assign resp_rdata = ((state_q == StResp) && !err_q && !we_q) ? ADDRW'(load_ext) : '0;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      we_q        <= 1'b0;
      funct3_q    <= 3'b000;
      lane_q      <= 2'b00;
      err_q       <= 1'b0;
      cnt_q       <= 3'd0;
      rdata_q     <= 32'h0;
      mem_addr_q  <= 14'h0;
      mem_wdata_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      funct3_q    <= funct3_d;
      lane_q      <= lane_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      rdata_q     <= rdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: RAM responder, byte-level reference model, directed and random traffic.
module tb_load_store_unit;

  localparam int unsigned DEPTH = 4096;
  localparam int unsigned LAT   = 3;

  logic        clk, reset;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [13:0] mem_addr;
  logic        mem_re, mem_we;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata, mem_rdata;

  load_store_unit #(.DEPTH(DEPTH), .ADDRW(32), .MEM_LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // RAM responder: data appears LAT cycles after the read strobe, garbage otherwise.
  logic [31:0] ram [DEPTH];
  bit          rd_pend = 0;
  int          rd_cnt = 0;
  logic [11:0] rd_idx;
  int          re_count = 0;
  logic [13:0] last_addr;
  logic [31:0] last_wdata;
  logic [3:0]  last_wstrb;

  always @(posedge clk) begin
    if (rd_pend && rd_cnt == 0) rd_pend = 0;
    else if (rd_pend) rd_cnt--;
    if (reset) rd_pend = 0;
    if (mem_we) begin
      for (int i = 0; i < 4; i++)
        if (mem_wstrb[i]) ram[mem_addr[13:2]][8*i +: 8] = mem_wdata[8*i +: 8];
      last_addr  = mem_addr;
      last_wdata = mem_wdata;
      last_wstrb = mem_wstrb;
    end
    if (mem_re) begin
      rd_pend = 1;
      rd_cnt  = LAT - 1;
      rd_idx  = mem_addr[13:2];
      last_addr = mem_addr;
      re_count++;
    end
    mem_rdata <= (rd_pend && rd_cnt == 0) ? ram[rd_idx] : $urandom;
  end

  // Reference model: one transaction at a time, tracked by age in cycles since acceptance.
  logic [7:0]  ref_mem [DEPTH*4];
  int          cyc = 0;
  bit          m_busy = 0;
  int          m_age, m_lat;
  logic        m_err, m_we;
  logic [31:0] m_rdata, m_wdata;
  logic [3:0]  m_strb;
  logic [13:0] m_addr;

  task automatic model_accept();
    int unsigned ea, sz;
    logic [31:0] v;
    logic [2:0]  f;
    f  = req_funct3;
    ea = req_addr & 32'h3FFF;
    sz = (f[1:0] == 2'd0) ? 1 : (f[1:0] == 2'd1) ? 2 : 4;
    m_err = (f == 3) || (f == 6) || (f == 7) || (req_we && f > 2) || (ea % sz != 0);
`ifdef LSU_BOUNDS_CHECK_EN
    if (req_addr >= DEPTH * 4) m_err = 1;
`endif
    m_we    = req_we;
    m_addr  = 14'(ea & 32'hFFFF_FFFC);
    m_strb  = 4'h0;
    m_wdata = 32'h0;
    m_rdata = 32'h0;
    if (!m_err) begin
      for (int i = 0; i < int'(sz); i++) m_strb[(ea % 4) + i] = 1'b1;
      for (int i = 0; i < 4; i++) m_wdata[8*i +: 8] = req_wdata[8*(i % sz) +: 8];
      if (req_we) begin
        for (int i = 0; i < int'(sz); i++) ref_mem[ea + i] = req_wdata[8*i +: 8];
      end else begin
        v = 32'h0;
        for (int i = 0; i < int'(sz); i++) v = v | (32'(ref_mem[ea + i]) << (8 * i));
        if (!f[2] && sz < 4 && v[8*sz-1]) v = v | (32'hFFFF_FFFF << (8 * sz));
        m_rdata = v;
      end
    end
    m_lat  = m_err ? 1 : (req_we ? 2 : 2 + LAT);
    m_busy = 1;
    m_age  = 1;
  endtask

  always @(posedge clk) begin
    cyc++;
    if (reset) m_busy = 0;
    else if (m_busy) begin
      if (m_age == m_lat) m_busy = 0;
      else m_age++;
    end else if (req_valid) model_accept();
  end

  // Compare process: every non-reset cycle against the model.
  bit          started = 0;
  bit          iss, rsp;
  int          dut_resp_cnt = 0;
  int          dut_resp_cyc = 0;
  logic [31:0] last_rdata;
  logic        last_err;

  always @(negedge clk) begin
    if (started && !reset) begin
      iss = m_busy && m_age == 1 && !m_err;
      rsp = m_busy && m_age == m_lat;
      chk("req_ready", 32'(req_ready), 32'(!m_busy));
      chk("resp_valid", 32'(resp_valid), 32'(rsp));
      chk("mem_re", 32'(mem_re), 32'(iss && !m_we));
      chk("mem_we", 32'(mem_we), 32'(iss && m_we));
      chk("mem_wstrb", 32'(mem_wstrb), (iss && m_we) ? 32'(m_strb) : 32'h0);
      if (iss) chk("mem_addr", 32'(mem_addr), 32'(m_addr));
      if (iss && m_we) chk("mem_wdata", mem_wdata, m_wdata);
      if (rsp) begin
        chk("resp_err", 32'(resp_err), 32'(m_err));
        chk("resp_rdata", resp_rdata, m_rdata);
      end
      if (resp_valid) begin
        dut_resp_cnt++;
        dut_resp_cyc = cyc;
        last_rdata   = resp_rdata;
        last_err     = resp_err;
      end
    end
  end

  int acc_cyc;
  int lat;

  // Called #1 after a posedge; returns #1 after the accepting edge with req_valid still high.
  task automatic present(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd);
    bit acc = 0;
    int n = 0;
    req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = req_ready;
      @(posedge clk);
      n++;
    end
    #1;
    if (!acc) chk("accept_timeout", 32'(acc), 32'd1);
    acc_cyc = cyc;
  endtask

  task automatic op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                    input logic [31:0] wd);
    int c0 = dut_resp_cnt;
    int n = 0;
    present(we, f3, addr, wd);
    req_valid = 1'b0;
    while (dut_resp_cnt == c0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (dut_resp_cnt == c0) chk("resp_timeout", 32'(dut_resp_cnt), 32'(c0 + 1));
    lat = dut_resp_cyc - acc_cyc + 1;  // cycles from accepting edge to the resp_valid cycle
  endtask

  int rc, c0, a2;
  logic [31:0] ra;

  initial begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      ram[i] = $urandom;
      for (int b = 0; b < 4; b++) ref_mem[4*i + b] = ram[i][8*b +: 8];
    end
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0;
    req_addr = 32'h0; req_wdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_mem_strobes", {29'd0, mem_re, mem_we, |mem_wstrb}, 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    started = 1;

    op(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
    chk("sw_latency", 32'(lat), 32'd2);
    chk("sw_err", 32'(last_err), 32'd0);
    chk("sw_addr", 32'(last_addr), 32'h10);
    chk("sw_wstrb", 32'(last_wstrb), 32'hF);
    op(1'b1, 3'b000, 32'h13, 32'h000000A5);
    chk("sb_wdata", last_wdata, 32'hA5A5A5A5);
    chk("sb_wstrb", 32'(last_wstrb), 32'h8);
    op(1'b1, 3'b010, 32'h10, 32'h80FF0011);
    op(1'b0, 3'b000, 32'h13, 32'h0);
    chk("lb_data", last_rdata, 32'hFFFFFF80);
    chk("load_latency", 32'(lat), 32'(2 + LAT));
    op(1'b0, 3'b100, 32'h13, 32'h0);
    chk("lbu_data", last_rdata, 32'h00000080);
    op(1'b0, 3'b101, 32'h12, 32'h0);
    chk("lhu_data", last_rdata, 32'h000080FF);
    op(1'b0, 3'b001, 32'h12, 32'h0);
    chk("lh_data", last_rdata, 32'hFFFF80FF);
    rc = re_count;
    op(1'b0, 3'b010, 32'h02, 32'h0);
    chk("lw_misalign_err", 32'(last_err), 32'd1);
    chk("err_latency", 32'(lat), 32'd1);
    chk("err_no_mem_re", 32'(re_count), 32'(rc));
    op(1'b0, 3'b011, 32'h0, 32'h0);
    chk("illegal_f3_err", 32'(last_err), 32'd1);
    op(1'b0, 3'b010, 32'h4000, 32'h0);
`ifdef LSU_BOUNDS_CHECK_EN
    chk("oob_err", 32'(last_err), 32'd1);
`else
    chk("wrap_err", 32'(last_err), 32'd0);
    chk("wrap_addr", 32'(last_addr), 32'd0);
`endif

    // Abort a load in WAIT with reset.
    c0 = dut_resp_cnt;
    present(1'b0, 3'b010, 32'h20, 32'h0);
    req_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_reset_ready", 32'(req_ready), 32'd1);
    repeat (LAT + 3) @(posedge clk);
    #1;
    chk("aborted_no_resp", 32'(dut_resp_cnt), 32'(c0));

    // Back-to-back: the second request is held until the first load completes.
    present(1'b0, 3'b010, 32'h10, 32'h0);
    present(1'b1, 3'b010, 32'h14, 32'h12345678);
    a2 = acc_cyc;
    chk("b2b_gap", 32'(a2 - dut_resp_cyc), 32'd2);  // RESP cycle, IDLE cycle, then accepting edge
    req_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    for (int k = 0; k < 300; k++) begin
      ra = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 7) == 0) ra = ra | ($urandom & 32'hFFFFC000);
      present(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), ra, $urandom);
      if ($urandom_range(0, 1) == 0) begin
        req_valid = 1'b0;
        repeat ($urandom_range(0, 3)) @(posedge clk);
        @(posedge clk); #1;
      end
    end
    req_valid = 1'b0;
    repeat (LAT + 6) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
